vram_fetch_arbiter: RTL and testbench
=====================================

Name: vram_fetch_arbiter

Overview:
- Shares one synchronous single-port VRAM between two users: the display line fetcher and a CPU requester.
- Once per scanline, triggered by the frame timing generator's hsyncStarting, it bursts one line of pixel words for nextVPos into a double-buffered line buffer.
- The CPU gets the VRAM in all remaining cycles through a req/ack handshake.
- Sits between the timing generator, VRAM, the line buffer and the CPU bus.

Parameters:
- FETCH_WORDS, 160, words fetched per scanline (320 px at 2 px/word); range 1..256.
- LINE_STRIDE, 160, VRAM words between consecutive display lines.
- ADDR_WIDTH, 16, VRAM word-address width.
- DATA_WIDTH, 16, VRAM data width.

Ports:
- clkPixel  in  1  pixel clock; the only clock.
- resetN  in  1  reset, asynchronous assert, active-low.
- hsyncStarting  in  1  one-cycle fetch trigger from the timing generator.
- nextFrameActive  in  1  next line is visible; qualifies the trigger.
- nextVPos  in  10  display line to fetch.
- cpuReq  in  1  CPU access request; held until cpuAck.
- cpuWe  in  1  1 = write, 0 = read; stable while cpuReq is high.
- cpuAddr  in  ADDR_WIDTH  CPU word address.
- cpuWData  in  DATA_WIDTH  CPU write data.
- cpuAck  out  1  one-cycle completion pulse.
- cpuRData  out  DATA_WIDTH  read data; valid with cpuAck, held until the next read completes.
- memAddr  out  ADDR_WIDTH  VRAM address (registered).
- memRe  out  1  VRAM read enable (registered).
- memWe  out  1  VRAM write enable (registered).
- memWData  out  DATA_WIDTH  VRAM write data (registered).
- memRData  in  DATA_WIDTH  VRAM read data; valid the cycle after the edge that samples memRe.
- lbWe  out  1  line-buffer write strobe.
- lbAddr  out  8  line-buffer word index.
- lbWData  out  DATA_WIDTH  line-buffer write data.
- lbBank  out  1  line-buffer bank currently being filled.
- fetchBusy  out  1  a fetch is in progress.
- fetchOverrun  out  1  one-cycle pulse when a trigger is dropped.

Behaviour:
- Reset: while resetN is low, every output and internal register is 0 and state is IDLE. Reset asserted mid-fetch or mid-CPU access abandons the operation; no cpuAck is issued.
- States: IDLE, FETCH, DRAIN, CPU_CMD, CPU_WAIT, CPU_ACK.
- Valid trigger = hsyncStarting & nextFrameActive, sampled on clkPixel. A trigger with nextFrameActive = 0 is ignored: no fetch, no bank toggle.
- IDLE priority: a pending or current valid trigger beats cpuReq.
- Fetch start (edge E0):
  - base = nextVPos * LINE_STRIDE, truncated to ADDR_WIDTH; latch base.
  - Toggle lbBank; set fetchBusy = 1; go to FETCH.
  - Word i is issued in cycle i after E0 (memRe = 1, memAddr = base + i).
- FETCH: issues FETCH_WORDS consecutive reads, one per cycle, with no gaps. Go to DRAIN after the read for word FETCH_WORDS-1 has been issued.
- Line-buffer writes: memRData for word i is registered to lbWData with lbWe = 1, lbAddr = i during cycle i+2. DRAIN lasts until the last lbWe.
- Fetch end: fetchBusy drops, and the FSM returns to IDLE, on the cycle after the last lbWe. Total fetchBusy high time is FETCH_WORDS + 2 cycles.
- CPU access, accepted at edge C0 in IDLE:
  - CPU_CMD: memAddr = cpuAddr, memWe = cpuWe, memRe = ~cpuWe, memWData = cpuWData.
  - CPU_WAIT: memory responds; memRe and memWe are 0.
  - CPU_ACK: cpuAck = 1 for exactly one cycle. For reads, cpuRData is updated from memRData at the same edge.
- CPU rules:
  - The requester drops cpuReq at the edge ending the cpuAck cycle.
  - A re-held cpuReq sampled in IDLE starts a new access.
  - Back-to-back accesses take 4 cycles each.
- Trigger during CPU_CMD, CPU_WAIT or CPU_ACK: latched as pending. The fetch starts at the first IDLE edge, so added delay is at most 3 cycles.
- Trigger during FETCH or DRAIN: dropped; fetchOverrun pulses for 1 cycle; lbBank unchanged.
- memRe and memWe are never both 1. memRe/memWe are 0 in IDLE, DRAIN (after the last issue) and CPU_WAIT/CPU_ACK.
- A CPU request arriving during a fetch waits, without loss, until the FSM returns to IDLE.

Test Plan:
- Reset state: assert resetN low mid-fetch -> all outputs 0 immediately. Release -> IDLE; the next trigger fetches into bank 1.
- Basic fetch: nextVPos = 5, nextFrameActive = 1, hsyncStarting pulse -> memAddr runs 800..959 on consecutive cycles. lbWe is high for 160 cycles with lbAddr 0..159 and lbWData equal to the preloaded VRAM words. lbBank toggles 0→1. fetchBusy is high for 162 cycles.
- CPU write then read: write 0xBEEF to address 0x1234, then read 0x1234 -> each cpuAck arrives 2 cycles after acceptance; the read returns cpuRData = 0xBEEF.
- Contention: cpuReq raised one cycle after the trigger -> the CPU access completes only after the fetch. cpuAck arrives FETCH_WORDS + 5 cycles after cpuReq, and no VRAM cycle conflicts.
- Pending trigger: trigger in the CPU_WAIT cycle -> cpuAck completes normally, then the fetch starts at the next IDLE edge with the nextVPos latched at the trigger.
- Overrun and blanking: a second trigger 50 cycles into a fetch -> fetchOverrun pulses once and the fetch continues unaltered. A trigger with nextFrameActive = 0 -> no memRe, lbBank unchanged.

Source files
------------

// File: rtl/vram_fetch_arbiter.sv
// vram_fetch_arbiter
//   Shares one synchronous single-port VRAM between the display line fetcher
//   and a CPU requester. A qualified hsync trigger bursts FETCH_WORDS words of
//   line nextVPos into the bank of a double-buffered line buffer. The CPU is
//   served in all other cycles through a req/ack handshake. Each CPU access
//   takes three cycles: CMD, WAIT, ACK.
//
// Ports
//   clkPixel, resetN      : pixel clock; asynchronous active-low reset
//   hsyncStarting         : one-cycle fetch trigger
//   nextFrameActive       : qualifies the trigger (next line visible)
//   nextVPos              : display line to fetch
//   cpuReq/cpuWe/cpuAddr/cpuWData : CPU request, held until cpuAck
//   cpuAck/cpuRData       : completion pulse; read data, held until next read
//   memAddr/memRe/memWe/memWData  : registered VRAM command
//   memRData              : VRAM read data, one cycle after memRe is sampled
//   lbWe/lbAddr/lbWData/lbBank    : line-buffer write port and bank being filled
//   fetchBusy             : fetch in progress
//   fetchOverrun          : one-cycle pulse when a trigger is dropped

module vram_fetch_arbiter #(
  parameter int FETCH_WORDS = 160,
  parameter int LINE_STRIDE = 160,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                  clkPixel,
  input  logic                  resetN,
  input  logic                  hsyncStarting,
  input  logic                  nextFrameActive,
  input  logic [9:0]            nextVPos,
  input  logic                  cpuReq,
  input  logic                  cpuWe,
  input  logic [ADDR_WIDTH-1:0] cpuAddr,
  input  logic [DATA_WIDTH-1:0] cpuWData,
  output logic                  cpuAck,
  output logic [DATA_WIDTH-1:0] cpuRData,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memRe,
  output logic                  memWe,
  output logic [DATA_WIDTH-1:0] memWData,
  input  logic [DATA_WIDTH-1:0] memRData,
  output logic                  lbWe,
  output logic [7:0]            lbAddr,
  output logic [DATA_WIDTH-1:0] lbWData,
  output logic                  lbBank,
  output logic                  fetchBusy,
  output logic                  fetchOverrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_CPU_CMD,
    S_CPU_WAIT,
    S_CPU_ACK
  } state_t;

  localparam logic [7:0] LAST_WORD = 8'(FETCH_WORDS - 1);

  state_t r_state;
  state_t w_state_next;

  // Registered outputs and internal state
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_re;
  logic                  r_mem_we;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [7:0]            r_word;
  logic                  r_cpu_rd;
  logic                  r_cpu_ack;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic                  r_fetch_busy;
  logic                  r_lb_bank;
  logic                  r_overrun;
  logic                  r_trig_pend;
  logic [9:0]            r_pend_vpos;
  logic                  r_rd_vld;
  logic [7:0]            r_rd_idx;
  logic                  r_lb_we;
  logic [7:0]            r_lb_addr;
  logic [DATA_WIDTH-1:0] r_lb_wdata;

  // Next values from the output process
  logic [ADDR_WIDTH-1:0] w_mem_addr_next;
  logic                  w_mem_re_next;
  logic                  w_mem_we_next;
  logic [DATA_WIDTH-1:0] w_mem_wdata_next;
  logic [7:0]            w_word_next;
  logic                  w_cpu_rd_next;
  logic                  w_cpu_ack_next;
  logic [DATA_WIDTH-1:0] w_cpu_rdata_next;

  logic                  w_trig;
  logic                  w_in_fetch;
  logic                  w_in_cpu;
  logic                  w_start_fetch;
  logic                  w_start_cpu;
  logic                  w_last_issue;
  logic [9:0]            w_vpos_sel;
  logic [ADDR_WIDTH-1:0] w_base;

  assign w_trig        = hsyncStarting & nextFrameActive;
  assign w_in_fetch    = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign w_in_cpu      = (r_state == S_CPU_CMD) || (r_state == S_CPU_WAIT) ||
                         (r_state == S_CPU_ACK);
  // A trigger latched during a CPU access beats both a new trigger and cpuReq.
  assign w_start_fetch = (r_state == S_IDLE) && (r_trig_pend || w_trig);
  assign w_start_cpu   = (r_state == S_IDLE) && !r_trig_pend && !w_trig && cpuReq;
  assign w_last_issue  = (r_state == S_FETCH) && (r_word == LAST_WORD);
  assign w_vpos_sel    = r_trig_pend ? r_pend_vpos : nextVPos;
  // Product truncated to the address width. The base is carried in
  // r_mem_addr, which then steps by one per issued word.
  assign w_base        = ADDR_WIDTH'(w_vpos_sel) * ADDR_WIDTH'(LINE_STRIDE);

  // State register
  always_ff @(posedge clkPixel or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_fetch) begin
          w_state_next = S_FETCH;
        end else if (w_start_cpu) begin
          w_state_next = S_CPU_CMD;
        end
      end
      S_FETCH:    if (w_last_issue) w_state_next = S_DRAIN;
      // Stay until the last read word has reached the line-buffer stage.
      S_DRAIN:    if (!r_rd_vld) w_state_next = S_IDLE;
      S_CPU_CMD:  w_state_next = S_CPU_WAIT;
      S_CPU_WAIT: w_state_next = S_CPU_ACK;
      S_CPU_ACK:  w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered VRAM command and CPU response
  always_comb begin
    w_mem_addr_next  = r_mem_addr;
    w_mem_re_next    = 1'b0;
    w_mem_we_next    = 1'b0;
    w_mem_wdata_next = r_mem_wdata;
    w_word_next      = r_word;
    w_cpu_rd_next    = r_cpu_rd;
    w_cpu_ack_next   = 1'b0;
    w_cpu_rdata_next = r_cpu_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_start_fetch) begin
          w_mem_addr_next = w_base;
          w_mem_re_next   = 1'b1;
          w_word_next     = 8'd0;
        end else if (w_start_cpu) begin
          w_mem_addr_next  = cpuAddr;
          w_mem_we_next    = cpuWe;
          w_mem_re_next    = ~cpuWe;
          w_mem_wdata_next = cpuWData;
          w_cpu_rd_next    = ~cpuWe;
        end
      end
      S_FETCH: begin
        if (!w_last_issue) begin
          w_mem_addr_next = r_mem_addr + ADDR_WIDTH'(1);
          w_mem_re_next   = 1'b1;
          w_word_next     = r_word + 8'd1;
        end
      end
      S_CPU_WAIT: begin
        // memRData is valid in this cycle for the command issued in CPU_CMD.
        w_cpu_ack_next = 1'b1;
        if (r_cpu_rd) w_cpu_rdata_next = memRData;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clkPixel or negedge resetN) begin
    if (!resetN) begin
      r_mem_addr   <= '0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
      r_word       <= 8'd0;
      r_cpu_rd     <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_fetch_busy <= 1'b0;
      r_lb_bank    <= 1'b0;
      r_overrun    <= 1'b0;
      r_trig_pend  <= 1'b0;
      r_pend_vpos  <= 10'd0;
      r_rd_vld     <= 1'b0;
      r_rd_idx     <= 8'd0;
      r_lb_we      <= 1'b0;
      r_lb_addr    <= 8'd0;
      r_lb_wdata   <= '0;
    end else begin
      r_mem_addr   <= w_mem_addr_next;
      r_mem_re     <= w_mem_re_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_word       <= w_word_next;
      r_cpu_rd     <= w_cpu_rd_next;
      r_cpu_ack    <= w_cpu_ack_next;
      r_cpu_rdata  <= w_cpu_rdata_next;
      r_fetch_busy <= (w_state_next == S_FETCH) || (w_state_next == S_DRAIN);
      r_lb_bank    <= r_lb_bank ^ w_start_fetch;
      // A trigger is dropped while fetching, or when one is already waiting.
      r_overrun    <= w_trig & (w_in_fetch | r_trig_pend);

      if (w_start_fetch) begin
        r_trig_pend <= 1'b0;
      end else if (w_in_cpu && w_trig && !r_trig_pend) begin
        r_trig_pend <= 1'b1;
        r_pend_vpos <= nextVPos;
      end

      // Two-stage line-buffer pipe: the read issued in cycle i returns in
      // cycle i+1 and is written to the line buffer in cycle i+2.
      r_rd_vld <= (r_state == S_FETCH);
      r_rd_idx <= r_word;
      r_lb_we  <= r_rd_vld;
      if (r_rd_vld) begin
        r_lb_addr  <= r_rd_idx;
        r_lb_wdata <= memRData;
      end
    end
  end

  assign cpuAck       = r_cpu_ack;
  assign cpuRData     = r_cpu_rdata;
  assign memAddr      = r_mem_addr;
  assign memRe        = r_mem_re;
  assign memWe        = r_mem_we;
  assign memWData     = r_mem_wdata;
  assign lbWe         = r_lb_we;
  assign lbAddr       = r_lb_addr;
  assign lbWData      = r_lb_wdata;
  assign lbBank       = r_lb_bank;
  assign fetchBusy    = r_fetch_busy;
  assign fetchOverrun = r_overrun;

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// Directed testbench for vram_fetch_arbiter with a behavioural VRAM model.
module tb_vram_fetch_arbiter;

  localparam int FW = 160;

  logic        clkPixel = 1'b0;
  logic        resetN;
  logic        hsyncStarting;
  logic        nextFrameActive;
  logic [9:0]  nextVPos;
  logic        cpuReq;
  logic        cpuWe;
  logic [15:0] cpuAddr;
  logic [15:0] cpuWData;
  logic        cpuAck;
  logic [15:0] cpuRData;
  logic [15:0] memAddr;
  logic        memRe;
  logic        memWe;
  logic [15:0] memWData;
  logic [15:0] memRData = 16'h0000;
  logic        lbWe;
  logic [7:0]  lbAddr;
  logic [15:0] lbWData;
  logic        lbBank;
  logic        fetchBusy;
  logic        fetchOverrun;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] vram [0:65535];

  vram_fetch_arbiter #(
    .FETCH_WORDS(FW), .LINE_STRIDE(160), .ADDR_WIDTH(16), .DATA_WIDTH(16)
  ) dut (
    .clkPixel(clkPixel), .resetN(resetN),
    .hsyncStarting(hsyncStarting), .nextFrameActive(nextFrameActive),
    .nextVPos(nextVPos),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
    .cpuAck(cpuAck), .cpuRData(cpuRData),
    .memAddr(memAddr), .memRe(memRe), .memWe(memWe), .memWData(memWData),
    .memRData(memRData),
    .lbWe(lbWe), .lbAddr(lbAddr), .lbWData(lbWData), .lbBank(lbBank),
    .fetchBusy(fetchBusy), .fetchOverrun(fetchOverrun)
  );

  always #5 clkPixel = ~clkPixel;

  // Synchronous single-port VRAM: data valid the cycle after memRe is sampled.
  always @(posedge clkPixel) begin
    if (memWe) vram[memAddr] <= memWData;
    if (memRe) memRData <= vram[memAddr];
  end

  function automatic logic [15:0] pat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3C3;
  endfunction

  task automatic tick;
    @(posedge clkPixel);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] all_outs();
    return {49'd0, cpuAck, cpuRData, memAddr, memRe, memWe, memWData,
            lbWe, lbAddr, lbWData, lbBank, fetchBusy, fetchOverrun};
  endfunction

  // Called in cycle 0 of a fetch (the cycle after the trigger edge).
  // inj >= 0 raises a second trigger in that cycle to provoke an overrun.
  task automatic run_fetch(input int base, input logic exp_bank, input int inj);
    int busy_cnt = 0;
    int we_cnt   = 0;
    int ovr_cnt  = 0;
    for (int c = 0; c < FW + 3; c++) begin
      if (c == inj) begin
        hsyncStarting = 1'b1; nextFrameActive = 1'b1; nextVPos = 10'd300;
      end else begin
        hsyncStarting = 1'b0;
      end
      chk("fetch_memRe", memRe, (c < FW));
      if (c < FW) chk("fetch_memAddr", memAddr, base + c);
      chk("fetch_memWe", memWe, 1'b0);
      chk("fetch_lbWe", lbWe, (c >= 2 && c < FW + 2));
      if (c >= 2 && c < FW + 2) begin
        chk("fetch_lbAddr", lbAddr, c - 2);
        chk("fetch_lbWData", lbWData, pat(16'(base + c - 2)));
      end
      chk("fetch_lbBank", lbBank, exp_bank);
      busy_cnt += int'(fetchBusy);
      we_cnt   += int'(lbWe);
      ovr_cnt  += int'(fetchOverrun);
      tick();
    end
    hsyncStarting = 1'b0;
    chk("fetch_busy_cycles", busy_cnt, 162);
    chk("fetch_lbWe_count", we_cnt, 160);
    chk("fetch_overrun_count", ovr_cnt, (inj >= 0) ? 1 : 0);
  endtask

  initial begin
    int n;
    int conflicts;
    int acks;
    for (int a = 0; a < 65536; a++) vram[a] = pat(16'(a));
    resetN = 1'b0; hsyncStarting = 1'b0; nextFrameActive = 1'b0; nextVPos = 10'd0;
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = 16'h0; cpuWData = 16'h0;

    // Reset state
    tick(); tick();
    chk("reset_outputs", all_outs(), 128'd0);
    resetN = 1'b1;
    tick();
    chk("idle_memRe", memRe, 1'b0);
    chk("idle_bank", lbBank, 1'b0);

    // Basic fetch of line 5 -> 800..959, bank 0->1
    hsyncStarting = 1'b1; nextFrameActive = 1'b1; nextVPos = 10'd5;
    tick();
    hsyncStarting = 1'b0;
    run_fetch(800, 1'b1, -1);

    // CPU write 0xBEEF to 0x1234
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 16'h1234; cpuWData = 16'hBEEF;
    tick();
    chk("wr_cmd_memWe", memWe, 1'b1);
    chk("wr_cmd_memRe", memRe, 1'b0);
    chk("wr_cmd_memAddr", memAddr, 16'h1234);
    chk("wr_cmd_memWData", memWData, 16'hBEEF);
    chk("wr_cmd_ack", cpuAck, 1'b0);
    tick();
    chk("wr_wait_memWe", memWe, 1'b0);
    chk("wr_wait_ack", cpuAck, 1'b0);
    tick();
    chk("wr_ack", cpuAck, 1'b1);
    cpuReq = 1'b0;
    tick();
    chk("wr_ack_one_cycle", cpuAck, 1'b0);

    // CPU read back 0x1234
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 16'h1234;
    tick();
    chk("rd_cmd_memRe", memRe, 1'b1);
    chk("rd_cmd_memWe", memWe, 1'b0);
    chk("rd_cmd_memAddr", memAddr, 16'h1234);
    tick();
    chk("rd_wait_memRe", memRe, 1'b0);
    chk("rd_wait_ack", cpuAck, 1'b0);
    tick();
    chk("rd_ack", cpuAck, 1'b1);
    chk("rd_data", cpuRData, 16'hBEEF);
    cpuReq = 1'b0;
    tick();
    chk("rd_data_held", cpuRData, 16'hBEEF);

    // Contention: cpuReq one cycle after trigger; line 2 -> 320..479
    hsyncStarting = 1'b1; nextFrameActive = 1'b1; nextVPos = 10'd2;
    tick();
    hsyncStarting = 1'b0;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 16'h0010;
    n = 0; conflicts = 0;
    while (!cpuAck && n < 400) begin
      if (memRe && memWe) conflicts++;
      if ((memRe || memWe) && memAddr == 16'h0010 && fetchBusy) conflicts++;
      tick();
      n++;
    end
    chk("cont_ack_latency", n, 165);
    chk("cont_rdata", cpuRData, 16'hD3C3);
    chk("cont_conflicts", conflicts, 0);
    chk("cont_bank", lbBank, 1'b0);
    cpuReq = 1'b0;
    tick();

    // Pending trigger during CPU_WAIT of a write; line 7 -> base 1120
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 16'h2000; cpuWData = 16'h1357;
    tick();                                    // CPU_CMD
    tick();                                    // CPU_WAIT
    hsyncStarting = 1'b1; nextFrameActive = 1'b1; nextVPos = 10'd7;
    tick();                                    // CPU_ACK
    hsyncStarting = 1'b0; nextVPos = 10'd9; cpuReq = 1'b0;
    chk("pend_ack", cpuAck, 1'b1);
    chk("pend_busy_in_ack", fetchBusy, 1'b0);
    tick();                                    // IDLE
    chk("pend_idle_memRe", memRe, 1'b0);
    chk("pend_idle_busy", fetchBusy, 1'b0);
    tick();                                    // fetch cycle 0
    run_fetch(1120, 1'b1, -1);

    // Overrun: second trigger 50 cycles into a fetch of line 1 -> 160..319
    hsyncStarting = 1'b1; nextFrameActive = 1'b1; nextVPos = 10'd1;
    tick();
    hsyncStarting = 1'b0;
    run_fetch(160, 1'b0, 50);

    // Blanking: trigger with nextFrameActive = 0 is ignored
    hsyncStarting = 1'b1; nextFrameActive = 1'b0; nextVPos = 10'd6;
    tick();
    hsyncStarting = 1'b0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      n += int'(memRe) + int'(fetchBusy) + int'(fetchOverrun);
      tick();
    end
    chk("blank_no_activity", n, 0);
    chk("blank_bank", lbBank, 1'b0);

    // Reset in the middle of a fetch of line 4
    hsyncStarting = 1'b1; nextFrameActive = 1'b1; nextVPos = 10'd4;
    tick();
    hsyncStarting = 1'b0;
    repeat (20) tick();
    chk("midfetch_busy", fetchBusy, 1'b1);
    #2 resetN = 1'b0;
    #1;
    chk("midfetch_reset_outputs", all_outs(), 128'd0);
    tick();
    resetN = 1'b1;
    tick();
    chk("post_reset_idle", all_outs(), 128'd0);
    hsyncStarting = 1'b1; nextFrameActive = 1'b1; nextVPos = 10'd3;
    tick();
    hsyncStarting = 1'b0;
    run_fetch(480, 1'b1, -1);

    // Reset during a CPU access: no cpuAck afterwards
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 16'h0010;
    tick();
    chk("abort_cmd_memRe", memRe, 1'b1);
    #2 resetN = 1'b0;
    cpuReq = 1'b0;
    tick();
    resetN = 1'b1;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      acks += int'(cpuAck);
      tick();
    end
    chk("abort_no_ack", acks, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
